// File: rtl/scan_pkg.sv
// Shared types, constants and the MISR step function for the scan-state controller.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam int SIG_WIDTH = 8;
  localparam logic [SIG_WIDTH-1:0] MISR_POLY = 8'h1D;

  // Galois-style step: the outgoing MSB is folded with the incoming bit
  function automatic logic [SIG_WIDTH-1:0] misr_step(input logic [SIG_WIDTH-1:0] sig,
                                                     input logic din);
    logic fb;
    fb = sig[SIG_WIDTH-1] ^ din;
    return {sig[SIG_WIDTH-2:0], 1'b0} ^ (fb ? MISR_POLY : {SIG_WIDTH{1'b0}});
  endfunction

endpackage

// File: rtl/scan_misr.sv
// 8-bit serial-input signature register; clear has priority over enable.
module scan_misr
  import scan_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic                 data_i,
  output logic [SIG_WIDTH-1:0] sig_o
);

  logic [SIG_WIDTH-1:0] sig_q;

  // signature register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= {SIG_WIDTH{1'b0}};
    end else if (clr_i) begin
      sig_q <= {SIG_WIDTH{1'b0}};
    end else if (en_i) begin
      sig_q <= misr_step(sig_q, data_i);
    end else begin
      sig_q <= sig_q;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/scan_state_ctrl.sv
// State register for a flop-free core plus a load/capture/unload scan sequencer
// whose unloaded responses are compacted into an 8-bit MISR.
module scan_state_ctrl
  import scan_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 test_mode,
  input  logic                 start,
  input  logic [7:0]           num_patterns,
  input  logic                 si,
  input  logic [WIDTH-1:0]     ppo,
  output logic [WIDTH-1:0]     ppi,
  output logic                 so,
  output logic                 scan_en,
  output logic                 busy,
  output logic                 done,
  output logic [SIG_WIDTH-1:0] signature
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] q_q;
  logic [BW-1:0]    bit_q;
  logic [7:0]       pat_q;
  logic [7:0]       npat_q;
  logic             scan_en_q;
  logic             busy_q;
  logic             done_q;
  logic             misr_clr_s;
  logic             misr_en_s;

  // Sequencer and state register; status outputs are registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      q_q       <= '0;
      bit_q     <= '0;
      pat_q     <= 8'd0;
      npat_q    <= 8'd0;
      scan_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (!test_mode) begin
      state_q   <= IDLE;
      q_q       <= ppo;
      bit_q     <= '0;
      pat_q     <= 8'd0;
      scan_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            npat_q <= num_patterns;
            pat_q  <= 8'd0;
            bit_q  <= '0;
            busy_q <= 1'b1;
            if (num_patterns == 8'd0) begin
              state_q   <= DONE;
              scan_en_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              state_q   <= SHIFT;
              scan_en_q <= 1'b1;
            end
          end else begin
            busy_q    <= 1'b0;
            scan_en_q <= 1'b0;
          end
        end
        SHIFT: begin
          q_q <= {q_q[WIDTH-2:0], si};
          if (bit_q == BIT_LAST) begin
            bit_q     <= '0;
            state_q   <= CAPTURE;
            scan_en_q <= 1'b0;
          end else begin
            bit_q <= bit_q + BW'(1);
          end
        end
        CAPTURE: begin
          q_q       <= ppo;
          pat_q     <= pat_q + 8'd1;
          scan_en_q <= 1'b1;
          state_q   <= ((pat_q + 8'd1) == npat_q) ? UNLOAD : SHIFT;
        end
        UNLOAD: begin
          q_q <= {q_q[WIDTH-2:0], 1'b0};
          if (bit_q == BIT_LAST) begin
            bit_q     <= '0;
            state_q   <= DONE;
            scan_en_q <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            bit_q <= bit_q + BW'(1);
          end
        end
        DONE: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          scan_en_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          scan_en_q <= 1'b0;
        end
      endcase
    end
  end

  // The first pattern's shift-out is stale power-up state, so it is not compacted
  assign misr_clr_s = test_mode && (state_q == IDLE) && start;
  assign misr_en_s  = test_mode &&
                      (((state_q == SHIFT) && (pat_q != 8'd0)) || (state_q == UNLOAD));

  scan_misr u_misr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (misr_clr_s),
    .en_i   (misr_en_s),
    .data_i (q_q[WIDTH-1]),
    .sig_o  (signature)
  );

  assign ppi     = q_q;
  assign so      = q_q[WIDTH-1];
  assign scan_en = scan_en_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: doc/scan_state_ctrl.md
# scan_state_ctrl

Scan-state register and test sequencer for the flip-flop-free combinational core that exposes pseudo-primary inputs/outputs (PPI/PPO). Holds the core's state bits, which are removed from the core, and drives them onto PPI. In functional mode it reloads them from PPO every cycle. In test mode it runs load/capture/unload sessions and compacts the unloaded responses into an 8-bit MISR signature.

## Interface
Parameters:
- WIDTH, default 2: number of state bits (PPI/PPO pairs); must be ≥2.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- test_mode  in  1  0 = functional, 1 = scan test.
- start  in  1  single-cycle request to begin a test session.
- num_patterns  in  8  patterns per session; sampled with start.
- si  in  1  serial scan data in.
- ppo  in  WIDTH  next-state bits from core.
- ppi  out  WIDTH  current state register q, to core.
- so  out  1  serial scan out, equals q[WIDTH-1].
- scan_en  out  1  high during SHIFT and UNLOAD.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at session end.
- signature  out  8  MISR value.

## Operation
- Reset values: q=0, so=0, scan_en=0, busy=0, done=0, signature=0, FSM in IDLE.
- Functional mode (test_mode=0): q <= ppo every cycle. FSM forced to IDLE. Signature holds.
- FSM states: IDLE, SHIFT, CAPTURE, UNLOAD, DONE.
- IDLE: when test_mode=1 and start=1, latch num_patterns and clear signature to 0. If num_patterns=0, go to DONE; otherwise go to SHIFT with pattern count 0. q holds in IDLE while test_mode=1.
- SHIFT (WIDTH cycles): q <= {q[WIDTH-2:0], si}, so the first bit shifted in ends up in the MSB. Then go to CAPTURE.
- CAPTURE (1 cycle): q <= ppo and pattern count increments. If count reaches num_patterns, go to UNLOAD; otherwise go to SHIFT.
- UNLOAD (WIDTH cycles): q <= {q[WIDTH-2:0], 1'b0}, si ignored. Then go to DONE.
- DONE (1 cycle): done=1, then go to IDLE.
- MISR update on every shift cycle that carries a captured response: all UNLOAD cycles and SHIFT cycles of pattern 2 onward. The first pattern's SHIFT output is not compacted.
  - fb = sig[7] ^ so.
  - sig <= {sig[6:0], 1'b0} ^ (fb ? 8'h1D : 8'h00).
- start while busy: ignored.
- test_mode falls mid-session: FSM returns to IDLE next cycle, done not pulsed, signature holds its partial value, and q resumes functional loading.
- rst mid-session: immediate return to reset values.

## Timing
- Functional: ppo sampled at edge n appears on ppi after edge n.
- Session of N≥1 patterns: start sampled at edge 0. SHIFT occupies edges 1..WIDTH. done is high for exactly the cycle after edge N·(WIDTH+1)+WIDTH.
- N=0: done is high the cycle after the start edge.
- so and signature are registered outputs: so reflects q, signature reflects the state after the last update.
- scan_en asserts the cycle after start is accepted and is low during CAPTURE.

## Structure
- Package scan_pkg:
  - state enum {IDLE, SHIFT, CAPTURE, UNLOAD, DONE}.
  - SIG_WIDTH=8.
  - MISR_POLY=8'h1D (x^8+x^4+x^3+x^2+1).
- Sub-module scan_misr: clear, enable, and data bit inputs; 8-bit signature output.
- Bit counter and pattern counter stay in the top module.

## Test plan
All scenarios use WIDTH=2.
- Reset: assert rst asynchronously mid-cycle → ppi=00, so=0, scan_en=0, busy=0, done=0, signature=00 immediately.
- Functional: test_mode=0, ppo=2'b10 → ppi=2'b10 after next edge; ppo=2'b01 → ppi=2'b01 one edge later.
- Single pattern: num_patterns=1, si=1 then 0, ppo=2'b01 at CAPTURE.
  - ppi=2'b10 after SHIFT, 2'b01 after CAPTURE.
  - so=0 then 1 during UNLOAD.
  - done high for one cycle, in the cycle after edge 5.
  - signature=8'h1D.
- Zero patterns: num_patterns=0 → done in the cycle after start, no scan_en, signature=8'h00.
- Abort: drop test_mode during second SHIFT cycle → busy=0 next cycle, no done pulse; ppi then follows ppo.
- Busy guard: pulse start during CAPTURE of a 2-pattern session → session length and signature identical to an undisturbed run.
